period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_if.sv | 21 ++
 rtl/period_meter.sv | 114 +++++++++++
 tb/tb_period_meter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Control and result bundle of period_meter: measurement enable in, period/high-time results and status out.
interface period_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             meas_en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             busy;

    modport master (
        input  meas_en,
        output period, high_time, valid, timeout, busy
    );

    modport slave (
        output meas_en,
        input  period, high_time, valid, timeout, busy
    );
endinterface

// File: rtl/period_meter.sv
// Measures the rising-edge-to-rising-edge period and high time of an asynchronous
// slow square wave in fast_clock cycles, with saturation timeout and back-to-back framing.
module period_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          fast_clock,
    input  logic          rst,
    input  logic          slow_in,
    period_meter_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;
    logic                   sync;
    logic                   edge_det;
    logic [CNT_W-1:0]       period_cnt;
    logic [CNT_W-1:0]       high_cnt;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;

    assign sync     = sync_ff[SYNC_STAGES-1];
    assign edge_det = sync & ~sync_d;

    // Metastability synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], slow_in};
            sync_d  <= sync;
        end
    end

    // Framing FSM; the closing edge of one interval is also the opening edge of the next
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.meas_en) begin
                        state  <= ARM;
                        busy_q <= 1'b1;
                    end
                end
                ARM: begin
                    if (!bus.meas_en) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (edge_det) begin
                        state      <= MEASURE;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (!bus.meas_en) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (edge_det) begin
                        period_q   <= period_cnt;
                        high_q     <= high_cnt;
                        valid_q    <= 1'b1;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end else if (period_cnt == CNT_MAX) begin
                        // No closing edge before saturation: rearm and wait for a fresh opening edge
                        timeout_q <= 1'b1;
                        state     <= ARM;
                    end else begin
                        period_cnt <= period_cnt + CNT_ONE;
                        if (sync) begin
                            high_cnt <= high_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for framing/enable/reset/async cases
// and a 4-bit instance for saturation timeout and the edge-at-saturation boundary.
module tb_period_meter;
    logic fast_clock = 1'b0;
    logic rst;
    logic slow_in;
    logic slow_in4;

    period_meter_if #(.CNT_W(16)) bus ();
    period_meter_if #(.CNT_W(4))  bus4 ();

    period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .fast_clock (fast_clock),
        .rst        (rst),
        .slow_in    (slow_in),
        .bus        (bus)
    );

    period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .fast_clock (fast_clock),
        .rst        (rst),
        .slow_in    (slow_in4),
        .bus        (bus4)
    );

    always #50 fast_clock = ~fast_clock;

    int checks = 0;
    int errors = 0;

    int tick, vcount, tcount, busy_hi, xcount, both;
    int first_v, last_v, pmin, pmax, hmin, hmax, gmin, gmax;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic clear_stats();
        tick = 0; vcount = 0; tcount = 0; busy_hi = 0; xcount = 0; both = 0;
        first_v = -1; last_v = -1;
        pmin = 1 << 30; pmax = -1; hmin = 1 << 30; hmax = -1;
        gmin = 1 << 30; gmax = -1;
    endtask

    // Observe the 16-bit instance once per cycle, away from the active edge
    task automatic sample();
        int p, h, g;
        @(negedge fast_clock);
        tick++;
        if ($isunknown({bus.period, bus.high_time, bus.valid, bus.timeout, bus.busy})) xcount++;
        if (bus.valid && bus.timeout) both++;
        if (bus.timeout) tcount++;
        if (bus.busy) busy_hi++;
        if (bus.valid) begin
            vcount++;
            if (first_v < 0) first_v = tick;
            else begin
                g = tick - last_v;
                if (g < gmin) gmin = g;
                if (g > gmax) gmax = g;
            end
            last_v = tick;
            p = int'(bus.period);
            h = int'(bus.high_time);
            if (p < pmin) pmin = p;
            if (p > pmax) pmax = p;
            if (h < hmin) hmin = h;
            if (h > hmax) hmax = h;
        end
    endtask

    task automatic run_wave(input int per, input int hi, input int cycles, input int tail);
        for (int i = 0; i < cycles; i++) begin
            @(posedge fast_clock); #1;
            slow_in = ((i % per) < hi);
            sample();
        end
        for (int i = 0; i < tail; i++) begin
            @(posedge fast_clock); #1;
            slow_in = 1'b0;
            sample();
        end
    endtask

    // Drop enable long enough to flush the synchronizer, then rearm
    task automatic restart();
        @(posedge fast_clock); #1;
        bus.meas_en = 1'b0;
        slow_in = 1'b0;
        repeat (4) @(posedge fast_clock);
        #1;
        bus.meas_en = 1'b1;
        @(posedge fast_clock);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.meas_en = 1'b1; bus4.meas_en = 1'b0;
        slow_in = 1'b0; slow_in4 = 1'b0;
        repeat (5) @(posedge fast_clock);
        @(negedge fast_clock);
        checks++; if (bus.period !== 16'd0) begin errors++; $display("FAIL reset_period got %0h exp 0", bus.period); end
        checks++; if (bus.high_time !== 16'd0) begin errors++; $display("FAIL reset_high got %0h exp 0", bus.high_time); end
        checks++; if (bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses got valid=%b timeout=%b exp 0 0", bus.valid, bus.timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0 (rst overrides meas_en)", bus.busy); end
        checks++; if (bus4.period !== 4'd0 || bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_dut4 got period=%0h busy=%b exp 0 0", bus4.period, bus4.busy); end
        @(posedge fast_clock); #1;
        rst = 1'b0;
        @(posedge fast_clock);
        @(negedge fast_clock);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_release_busy got %b exp 1", bus.busy); end
    endtask

    task automatic test_basic();
        restart(); clear_stats();
        run_wave(8, 4, 80, 6);
        checks++; if (vcount !== 9) begin errors++; $display("FAIL basic_vcount got %0d exp 9", vcount); end
        checks++; if (first_v !== 12) begin errors++; $display("FAIL basic_first_valid got tick %0d exp 12", first_v); end
        checks++; if (pmin !== 8 || pmax !== 8) begin errors++; $display("FAIL basic_period got %0d..%0d exp 8", pmin, pmax); end
        checks++; if (hmin !== 4 || hmax !== 4) begin errors++; $display("FAIL basic_high got %0d..%0d exp 4", hmin, hmax); end
        checks++; if (gmin !== 8 || gmax !== 8) begin errors++; $display("FAIL basic_gap got %0d..%0d exp 8", gmin, gmax); end
        checks++; if (tcount !== 0 || both !== 0 || xcount !== 0) begin errors++; $display("FAIL basic_misc got timeout=%0d both=%0d x=%0d exp 0 0 0", tcount, both, xcount); end
    endtask

    task automatic test_divider();
        restart(); clear_stats();
        run_wave(16, 8, 96, 6);
        checks++; if (vcount !== 5) begin errors++; $display("FAIL div16_vcount got %0d exp 5", vcount); end
        checks++; if (pmin !== 16 || pmax !== 16 || hmin !== 8 || hmax !== 8) begin errors++; $display("FAIL div16_values got p=%0d..%0d h=%0d..%0d exp 16 8", pmin, pmax, hmin, hmax); end
        restart(); clear_stats();
        run_wave(2, 1, 40, 6);
        checks++; if (vcount !== 19) begin errors++; $display("FAIL div2_vcount got %0d exp 19", vcount); end
        checks++; if (pmin !== 2 || pmax !== 2 || hmin !== 1 || hmax !== 1) begin errors++; $display("FAIL div2_values got p=%0d..%0d h=%0d..%0d exp 2 1", pmin, pmax, hmin, hmax); end
        checks++; if (gmin !== 2 || gmax !== 2) begin errors++; $display("FAIL div2_gap got %0d..%0d exp 2", gmin, gmax); end
    endtask

    task automatic test_meas_en_drop();
        restart(); clear_stats();
        run_wave(10, 5, 40, 6);
        checks++; if (vcount !== 3 || pmax !== 10 || hmax !== 5) begin errors++; $display("FAIL drop_pre got v=%0d p=%0d h=%0d exp 3 10 5", vcount, pmax, hmax); end
        @(posedge fast_clock); #1;
        bus.meas_en = 1'b0;
        @(posedge fast_clock);
        clear_stats();
        sample();
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL drop_idle got busy=%b valid=%b exp 0 0", bus.busy, bus.valid); end
        checks++; if (bus.period !== 16'd10 || bus.high_time !== 16'd5) begin errors++; $display("FAIL drop_hold got p=%0d h=%0d exp 10 5", bus.period, bus.high_time); end
        clear_stats();
        run_wave(10, 5, 30, 6);
        checks++; if (vcount !== 0 || busy_hi !== 0 || tcount !== 0) begin errors++; $display("FAIL drop_disabled got v=%0d busy=%0d t=%0d exp 0 0 0", vcount, busy_hi, tcount); end
        checks++; if (bus.period !== 16'd10 || bus.high_time !== 16'd5) begin errors++; $display("FAIL drop_hold2 got p=%0d h=%0d exp 10 5", bus.period, bus.high_time); end
        @(posedge fast_clock); #1;
        bus.meas_en = 1'b1;
        clear_stats();
        run_wave(14, 4, 28, 6);
        checks++; if (vcount !== 1 || first_v !== 18) begin errors++; $display("FAIL reenable_first got v=%0d tick=%0d exp 1 18", vcount, first_v); end
        checks++; if (pmax !== 14 || hmax !== 4) begin errors++; $display("FAIL reenable_values got p=%0d h=%0d exp 14 4", pmax, hmax); end
    endtask

    task automatic test_rst_mid();
        restart(); clear_stats();
        run_wave(10, 5, 25, 0);
        @(posedge fast_clock); #1;
        rst = 1'b1; slow_in = 1'b0;
        @(posedge fast_clock); #1;
        rst = 1'b0;
        @(negedge fast_clock);
        checks++; if (bus.period !== 16'd0 || bus.high_time !== 16'd0) begin errors++; $display("FAIL rstmid_results got p=%0d h=%0d exp 0 0", bus.period, bus.high_time); end
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL rstmid_status got b=%b v=%b t=%b exp 0 0 0", bus.busy, bus.valid, bus.timeout); end
        clear_stats();
        run_wave(12, 3, 72, 6);
        checks++; if (vcount !== 5 || first_v !== 16) begin errors++; $display("FAIL rstmid_after got v=%0d first=%0d exp 5 16", vcount, first_v); end
        checks++; if (pmin !== 12 || pmax !== 12 || hmin !== 3 || hmax !== 3) begin errors++; $display("FAIL rstmid_values got p=%0d..%0d h=%0d..%0d exp 12 3", pmin, pmax, hmin, hmax); end
    endtask

    task automatic test_async();
        restart(); clear_stats();
        fork
            begin
                #33;
                repeat (8) begin
                    slow_in = 1'b1; #373;
                    slow_in = 1'b0; #427;
                end
            end
            begin
                repeat (75) sample();
            end
        join
        checks++; if (vcount !== 7) begin errors++; $display("FAIL async_vcount got %0d exp 7", vcount); end
        checks++; if (pmin < 7 || pmax > 9) begin errors++; $display("FAIL async_period got %0d..%0d exp 7..9", pmin, pmax); end
        checks++; if (hmin < 3 || hmax > 5) begin errors++; $display("FAIL async_high got %0d..%0d exp 3..5", hmin, hmax); end
        checks++; if (xcount !== 0 || tcount !== 0) begin errors++; $display("FAIL async_clean got x=%0d timeout=%0d exp 0 0", xcount, tcount); end
    endtask

    function automatic logic pat4(input int i);
        return (i < 3) || (i >= 6 && i < 9) || (i >= 40 && i < 43) ||
               (i >= 50 && i < 53) || (i >= 65 && i < 68);
    endfunction

    task automatic test_timeout();
        int vt[$], pv[$], hv[$], tt[$], tp[$];
        int exp_vt[3] = '{9, 53, 68};
        int exp_pv[3] = '{6, 10, 15};
        int exp_tt[2] = '{24, 83};
        int exp_tp[2] = '{6, 15};
        int busy_lo = 0;
        int overlap = 0;
        @(posedge fast_clock); #1;
        bus4.meas_en = 1'b1;
        repeat (2) @(posedge fast_clock);
        for (int i = 0; i < 90; i++) begin
            @(posedge fast_clock); #1;
            slow_in4 = pat4(i);
            @(negedge fast_clock);
            if (bus4.valid) begin vt.push_back(i); pv.push_back(int'(bus4.period)); hv.push_back(int'(bus4.high_time)); end
            if (bus4.timeout) begin tt.push_back(i); tp.push_back(int'(bus4.period)); end
            if (bus4.valid && bus4.timeout) overlap++;
            if (bus4.busy !== 1'b1) busy_lo++;
        end
        checks++; if (vt.size() != 3) begin errors++; $display("FAIL sat_vcount got %0d exp 3", vt.size()); end
        for (int k = 0; k < vt.size() && k < 3; k++) begin
            checks++;
            if (vt[k] !== exp_vt[k] || pv[k] !== exp_pv[k] || hv[k] !== 3) begin
                errors++;
                $display("FAIL sat_valid%0d got tick=%0d p=%0d h=%0d exp %0d %0d 3", k, vt[k], pv[k], hv[k], exp_vt[k], exp_pv[k]);
            end
        end
        checks++; if (tt.size() != 2) begin errors++; $display("FAIL sat_tcount got %0d exp 2", tt.size()); end
        for (int k = 0; k < tt.size() && k < 2; k++) begin
            checks++;
            if (tt[k] !== exp_tt[k] || tp[k] !== exp_tp[k]) begin
                errors++;
                $display("FAIL sat_timeout%0d got tick=%0d p=%0d exp %0d %0d", k, tt[k], tp[k], exp_tt[k], exp_tp[k]);
            end
        end
        checks++; if (busy_lo !== 0 || overlap !== 0) begin errors++; $display("FAIL sat_busy_overlap got busy_lo=%0d overlap=%0d exp 0 0", busy_lo, overlap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_meas_en_drop();
        test_rst_mid();
        test_async();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
